// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state encoding and mode constants for serial_subtractor
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic MODE_SUB = 1'b0;
    localparam logic MODE_ADD = 1'b1;

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/done handshake bundle; mode exists only under SERIAL_SUB_ADD_EN
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_SUB_ADD_EN
    logic             mode;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

`ifdef SERIAL_SUB_ADD_EN
    modport master (output start, a, b, mode, input busy, done, diff, borrow);
    modport slave  (input start, a, b, mode, output busy, done, diff, borrow);
`else
    modport master (output start, a, b, input busy, done, diff, borrow);
    modport slave  (input start, a, b, output busy, done, diff, borrow);
`endif

endinterface

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit full-subtractor cell; add/subtract select under SERIAL_SUB_ADD_EN
module full_subtractor
    import serial_sub_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic bin,
`ifdef SERIAL_SUB_ADD_EN
    input  logic mode,
`endif
    output logic d,
    output logic bout
);

    logic bout_sub;

    assign d        = x ^ y ^ bin;
    assign bout_sub = (~x & y) | (~(x ^ y) & bin);

`ifdef SERIAL_SUB_ADD_EN
    // In add mode bin/bout carry the carry chain instead of the borrow chain.
    assign bout = (mode == MODE_ADD) ? ((x & y) | ((x ^ y) & bin)) : bout_sub;
`else
    assign bout = bout_sub;
`endif

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first a-b (a+b with SERIAL_SUB_ADD_EN), start/done sequenced
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             last_bit;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff_q;
    logic             bin_q;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             bout;
`ifdef SERIAL_SUB_ADD_EN
    logic             mode_q;
`endif

    full_subtractor u_cell (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .bin  (bin_q),
`ifdef SERIAL_SUB_ADD_EN
        .mode (mode_q),
`endif
        .d    (d),
        .bout (bout)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The DONE cycle doubles as the re-accept slot so back-to-back ops run every WIDTH+1 cycles.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            diff_q <= '0;
            bin_q  <= 1'b0;
            cnt    <= '0;
`ifdef SERIAL_SUB_ADD_EN
            mode_q <= MODE_SUB;
`endif
        end else if (load) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            diff_q <= '0;
            bin_q  <= 1'b0;
            cnt    <= '0;
`ifdef SERIAL_SUB_ADD_EN
            mode_q <= bus.mode;
`endif
        end else if (state == SHIFT) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            diff_q <= {d, diff_q[WIDTH-1:1]};
            bin_q  <= bout;
            cnt    <= cnt + CW'(1);
        end
    end

    assign bus.busy   = (state == SHIFT);
    assign bus.done   = (state == DONE);
    assign bus.diff   = diff_q;
    assign bus.borrow = bin_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor (SERIAL_SUB_ADD_EN aware)
module tb_serial_subtractor;

    localparam int W = 4;

    typedef struct {
        int           cyc;
        logic [W-1:0] diff;
        logic         brw;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain (W+1)-bit arithmetic; the top bit is borrow (or carry when adding).
    task automatic push(input logic [W-1:0] av, input logic [W-1:0] bv, input logic m, input int done_cyc);
        logic [W:0] r;
        exp_t e;
        if (m) r = {1'b0, av} + {1'b0, bv};
        else   r = {1'b0, av} - {1'b0, bv};
        e.cyc  = done_cyc;
        e.diff = r[W-1:0];
        e.brw  = r[W];
        exp_q.push_back(e);
    endtask

    task automatic set_mode(input logic m);
`ifdef SERIAL_SUB_ADD_EN
        bus.mode = m;
`else
        if (m) $display("note: add mode requested without SERIAL_SUB_ADD_EN");
`endif
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pending result", cyc);
            end else begin
                e = exp_q.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("diff", int'(bus.diff), int'(e.diff));
                check("borrow", int'(bus.borrow), int'(e.brw));
            end
        end
    end

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic m);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        set_mode(m);
        push(av, bv, m, cyc + 1 + W);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check("busy_in_shift", int'(bus.busy), 1);
            check("no_early_done", int'(bus.done), 0);
        end
        @(negedge clk);
        check("busy_at_done", int'(bus.busy), 0);
        check("done_pulse", int'(bus.done), 1);
        @(posedge clk); #1;
        check("done_one_cycle", int'(bus.done), 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        set_mode(1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_diff", int'(bus.diff), 0);
        check("rst_borrow", int'(bus.borrow), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op(4'd9, 4'd3, 1'b0);
        run_op(4'd3, 4'd9, 1'b0);
        run_op(4'd0, 4'd1, 1'b0);
        run_op(4'd15, 4'd15, 1'b0);
        run_op(4'd15, 4'd0, 1'b0);

        // Exhaustive sweep, start held high: a new accept every W+1 cycles.
        @(posedge clk); #1;
        bus.start = 1'b1;
        set_mode(1'b0);
        for (int i = 0; i < 256; i++) begin
            bus.a = W'(i >> 4);
            bus.b = W'(i & 15);
            push(W'(i >> 4), W'(i & 15), 1'b0, cyc + 1 + W);
            @(posedge clk); #1;
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            repeat (W) @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        repeat (3) @(posedge clk);

        // Second start during SHIFT must be ignored.
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.a     = 4'd9;
        bus.b     = 4'd3;
        push(4'd9, 4'd3, 1'b0, cyc + 1 + W);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.a     = 4'd1;
        bus.b     = 4'd14;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (W + 3) @(posedge clk);

        // Reset in the second SHIFT cycle: immediate clear, no done pulse.
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.a     = 4'd9;
        bus.b     = 4'd2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_done", int'(bus.done), 0);
        check("midrst_diff", int'(bus.diff), 0);
        check("midrst_borrow", int'(bus.borrow), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (W + 2) @(posedge clk);
        run_op(4'd7, 4'd2, 1'b0);

`ifdef SERIAL_SUB_ADD_EN
        run_op(4'd9, 4'd9, 1'b1);
        run_op(4'd9, 4'd3, 1'b0);
`endif

        for (int i = 0; i < 20; i++) begin
`ifdef SERIAL_SUB_ADD_EN
            run_op(W'($urandom), W'($urandom), 1'($urandom));
`else
            run_op(W'($urandom), W'($urandom), 1'b0);
`endif
        end

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        check("pending_results", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
